// File: rtl/inst_buffer_if.sv
// Fetch/Dispatch side bundle of the N-wide instruction buffer.
// The master modport is the fetch/dispatch side; the slave modport is the buffer.
interface inst_buffer_if #(
  parameter int N      = 3,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
);
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int CNT_BITS        = $clog2(DEPTH + 1);

  logic [NUM_SCALAR_BITS-1:0] fetch_count;
  logic [N*DATA_W-1:0]        fetch_inst;
  logic [N*DATA_W-1:0]        fetch_PC;
  logic [N*DATA_W-1:0]        fetch_NPC;
  logic [NUM_SCALAR_BITS-1:0] buffer_spots;
  logic [NUM_SCALAR_BITS-1:0] inst_buffer_instructions_valid;
  logic [N*DATA_W-1:0]        out_inst;
  logic [N*DATA_W-1:0]        out_PC;
  logic [N*DATA_W-1:0]        out_NPC;
  logic [NUM_SCALAR_BITS-1:0] num_dispatched;
  logic                       restore_valid;
  logic [CNT_BITS-1:0]        occupancy;

  modport master (
    output fetch_count, fetch_inst, fetch_PC, fetch_NPC,
    output num_dispatched, restore_valid,
    input  buffer_spots, inst_buffer_instructions_valid,
    input  out_inst, out_PC, out_NPC, occupancy
  );

  modport slave (
    input  fetch_count, fetch_inst, fetch_PC, fetch_NPC,
    input  num_dispatched, restore_valid,
    output buffer_spots, inst_buffer_instructions_valid,
    output out_inst, out_PC, out_NPC, occupancy
  );
endinterface

// File: rtl/inst_buffer.sv
// N-wide circular instruction FIFO between fetch and Dispatch, flushed on branch restore.
// All outputs derive from registered state only; there is no input-to-output path.
module inst_buffer #(
  parameter int N      = 3,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  inst_buffer_if.slave  bus
);
  localparam int SB       = $clog2(N + 1);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int PTR_W    = $clog2(DEPTH);

  logic [DATA_W-1:0]   mem_inst [DEPTH];
  logic [DATA_W-1:0]   mem_pc   [DEPTH];
  logic [DATA_W-1:0]   mem_npc  [DEPTH];

  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_BITS-1:0] count;

  logic [SB-1:0]       spots;
  logic [SB-1:0]       avail;
  logic [SB-1:0]       accepted;
  logic [SB-1:0]       popped;
  logic [PTR_W-1:0]    rd_idx [N];
  logic [PTR_W-1:0]    wr_idx [N];

  // Saturate an entry count to the lane width (at most N lanes per cycle).
  function automatic logic [SB-1:0] sat_lanes(input logic [CNT_BITS-1:0] v);
    if (v > CNT_BITS'(N)) return SB'(N);
    else                  return SB'(v);
  endfunction

  function automatic logic [SB-1:0] min_lanes(input logic [SB-1:0] a,
                                              input logic [SB-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Lane budgets from start-of-cycle state; pops do not credit free spots.
  always_comb begin
    spots    = sat_lanes(CNT_BITS'(DEPTH) - count);
    avail    = sat_lanes(count);
    accepted = min_lanes(bus.fetch_count, spots);
    popped   = min_lanes(bus.num_dispatched, avail);
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      rd_idx[k] = head + PTR_W'(k);
      wr_idx[k] = tail + PTR_W'(k);
    end
  end

  assign bus.buffer_spots                   = spots;
  assign bus.inst_buffer_instructions_valid = avail;
  assign bus.occupancy                      = count;

  // Read lanes; invalid lanes are forced to zero so stale storage never leaks out.
  always_comb begin
    bus.out_inst = '0;
    bus.out_PC   = '0;
    bus.out_NPC  = '0;
    for (int k = 0; k < N; k++) begin
      if (SB'(k) < avail) begin
        bus.out_inst[k*DATA_W +: DATA_W] = mem_inst[rd_idx[k]];
        bus.out_PC[k*DATA_W +: DATA_W]   = mem_pc[rd_idx[k]];
        bus.out_NPC[k*DATA_W +: DATA_W]  = mem_npc[rd_idx[k]];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.restore_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(popped);
      tail  <= tail + PTR_W'(accepted);
      count <= count + CNT_BITS'(accepted) - CNT_BITS'(popped);
    end
  end

  // Storage carries no reset; entries outside head..head+count-1 are never observed.
  always_ff @(posedge clock) begin
    if (!bus.restore_valid) begin
      for (int k = 0; k < N; k++) begin
        if (SB'(k) < accepted) begin
          mem_inst[wr_idx[k]] <= bus.fetch_inst[k*DATA_W +: DATA_W];
          mem_pc[wr_idx[k]]   <= bus.fetch_PC[k*DATA_W +: DATA_W];
          mem_npc[wr_idx[k]]  <= bus.fetch_NPC[k*DATA_W +: DATA_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Randomised scoreboard bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;
  localparam int N   = 3;
  localparam int DEPTH = 16;
  localparam int DW  = 32;
  localparam int SB  = $clog2(N + 1);

  logic clock = 1'b0;
  logic reset = 1'b0;

  inst_buffer_if #(.N(N), .DEPTH(DEPTH), .DATA_W(DW)) bus ();
  inst_buffer #(.N(N), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] inst;
    logic [DW-1:0] pc;
    logic [DW-1:0] npc;
  } entry_t;

  typedef struct {
    int            cyc;
    string         tag;
    int            spots;
    int            valid;
    int            occ;
    logic [N*DW-1:0] inst;
    logic [N*DW-1:0] pc;
    logic [N*DW-1:0] npc;
  } exp_t;

  entry_t        model_q[$];
  exp_t          exp_q[$];
  int            cyc     = 0;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] pc_ctr  = '0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Expected visible state of a FIFO holding model_q.
  function automatic exp_t expect_now(input int c, input string tag);
    exp_t e;
    e.cyc   = c;
    e.tag   = tag;
    e.occ   = model_q.size();
    e.valid = imin(model_q.size(), N);
    e.spots = imin(DEPTH - model_q.size(), N);
    e.inst  = '0;
    e.pc    = '0;
    e.npc   = '0;
    for (int k = 0; k < e.valid; k++) begin
      e.inst[k*DW +: DW] = model_q[k].inst;
      e.pc[k*DW +: DW]   = model_q[k].pc;
      e.npc[k*DW +: DW]  = model_q[k].npc;
    end
    return e;
  endfunction

  function automatic void check_outputs(input exp_t e);
    check({e.tag, " spots"},     128'(bus.buffer_spots), 128'(e.spots));
    check({e.tag, " valid"},     128'(bus.inst_buffer_instructions_valid), 128'(e.valid));
    check({e.tag, " occupancy"}, 128'(bus.occupancy), 128'(e.occ));
    check({e.tag, " out_inst"},  128'(bus.out_inst), 128'(e.inst));
    check({e.tag, " out_PC"},    128'(bus.out_PC), 128'(e.pc));
    check({e.tag, " out_NPC"},   128'(bus.out_NPC), 128'(e.npc));
  endfunction

  // Monitor: compare whatever expectation is due in this cycle.
  always @(negedge clock) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      if (e.cyc != cyc) check({e.tag, " stale expectation"}, 128'(cyc), 128'(e.cyc));
      else              check_outputs(e);
    end
  end

  task automatic drive_idle();
    bus.fetch_count    = '0;
    bus.num_dispatched = '0;
    bus.restore_valid  = 1'b0;
    bus.fetch_inst     = '0;
    bus.fetch_PC       = '0;
    bus.fetch_NPC      = '0;
  endtask

  // Issue one cycle of stimulus, advance the model, queue the post-edge expectation.
  task automatic step(input int fc, input int nd, input bit rv, input string tag);
    int     spots;
    int     valid;
    int     acc;
    int     pop;
    entry_t en;
    spots = imin(DEPTH - model_q.size(), N);
    valid = imin(model_q.size(), N);
    acc   = rv ? 0 : imin(fc, spots);
    pop   = rv ? 0 : imin(nd, valid);
    bus.fetch_count    = SB'(fc);
    bus.num_dispatched = SB'(nd);
    bus.restore_valid  = rv;
    for (int i = 0; i < pop; i++) void'(model_q.pop_front());
    if (rv) model_q.delete();
    for (int k = 0; k < N; k++) begin
      en.inst = $urandom;
      en.pc   = (k < fc) ? pc_ctr + DW'(4 * k) : $urandom;
      en.npc  = $urandom;
      bus.fetch_inst[k*DW +: DW] = en.inst;
      bus.fetch_PC[k*DW +: DW]   = en.pc;
      bus.fetch_NPC[k*DW +: DW]  = en.npc;
      if (k < acc) model_q.push_back(en);
    end
    pc_ctr = pc_ctr + DW'(4 * acc);
    exp_q.push_back(expect_now(cyc + 1, tag));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    drive_idle();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.push_back(expect_now(cyc, "reset_release"));

    // Reset release and first push
    step(3, 0, 1'b0, "t1_push");
    check("t1 valid const", 128'(bus.inst_buffer_instructions_valid), 128'(3));
    check("t1 out_PC const", 128'(bus.out_PC), 128'({32'h8, 32'h4, 32'h0}));
    step(0, 0, 1'b1, "t1_flush");

    // Fill to full, push+pop while full, drain
    repeat (6) step(3, 0, 1'b0, "t2_fill");
    check("t2 occupancy cap", 128'(bus.occupancy), 128'(16));
    check("t2 spots at full", 128'(bus.buffer_spots), 128'(0));
    step(3, 2, 1'b0, "t2_full_pushpop");
    repeat (6) step(0, 3, 1'b0, "t2_drain");

    // Simultaneous push and pop
    step(3, 0, 1'b0, "t3_fill");
    step(2, 0, 1'b0, "t3_fill");
    step(3, 2, 1'b0, "t3_pushpop");
    check("t3 occupancy const", 128'(bus.occupancy), 128'(6));
    repeat (2) step(0, 3, 1'b0, "t3_drain");

    // Async reset between edges at occupancy 7
    step(3, 0, 1'b0, "t6_fill");
    step(3, 0, 1'b0, "t6_fill");
    step(1, 0, 1'b0, "t6_fill");
    drive_idle();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    exp_q.delete();
    check_outputs(expect_now(cyc, "t6_async"));
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.push_back(expect_now(cyc, "t6_release"));

    // Wrap: reach head=14 count=4, then push three lanes across 15->0
    repeat (4) step(3, 0, 1'b0, "t4_fill");
    step(3, 3, 1'b0, "t4_move");
    step(1, 3, 1'b0, "t4_move");
    repeat (2) step(0, 3, 1'b0, "t4_move");
    step(2, 2, 1'b0, "t4_wrap_read");
    repeat (4) step(3, 0, 1'b0, "t4_refill");
    repeat (2) step(0, 3, 1'b0, "t4_pop");
    step(3, 0, 1'b0, "t4_wrap_push");
    repeat (5) step(0, 3, 1'b0, "t4_drain");

    // Flush priority over push and pop
    repeat (3) step(3, 0, 1'b0, "t5_fill");
    step(3, 2, 1'b1, "t5_flush");
    check("t5 valid after flush", 128'(bus.inst_buffer_instructions_valid), 128'(0));
    step(3, 0, 1'b0, "t5_refill");

    // Random traffic: fill-leaning phase then balanced phase
    repeat (200) step($urandom_range(0, N), $urandom_range(0, 1),
                      ($urandom_range(0, 29) == 0), "rand_fill");
    repeat (250) step($urandom_range(0, N), $urandom_range(0, N),
                      ($urandom_range(0, 19) == 0), "rand_mix");

    drive_idle();
    repeat (2) @(posedge clock);
    #1;
    check("scoreboard drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
